// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared state encoding and coin constants for the vending controller
package vm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_VEND   = 2'd2,
      ST_CHANGE = 2'd3
   } vm_state_t;

   localparam int HALF_V = 1;
   localparam int ONE_V  = 2;

   // coin inputs decoded as {one, half}
   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_HALF = 2'b01;
   localparam logic [1:0] COIN_ONE  = 2'b10;
   localparam logic [1:0] COIN_BOTH = 2'b11;

endpackage

// File: rtl/vm_change_dispenser.sv
// rtl/vm_change_dispenser.sv - pays a loaded amount out as one 1.0 or 0.5 coin pulse per cycle
module vm_change_dispenser
   import vm_pkg::*;
#(
   parameter int CW = 4
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          load,
   input  logic [CW-1:0] amount,
   output logic          coin_one,
   output logic          coin_half,
   output logic [CW-1:0] next_amount,
   output logic          done
);

   logic [CW-1:0] owed;      // still owed, including the coin pulse shown this cycle
   logic [CW-1:0] upcoming;

   always_comb begin
      next_amount = '0;
      if (owed >= CW'(ONE_V))
         next_amount = owed - CW'(ONE_V);
      else if (owed >= CW'(HALF_V))
         next_amount = owed - CW'(HALF_V);
   end

   assign done     = (owed != '0) && (next_amount == '0);
   assign upcoming = load ? amount : next_amount;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         owed      <= '0;
         coin_one  <= 1'b0;
         coin_half <= 1'b0;
      end else begin
         owed      <= upcoming;
         coin_one  <= (upcoming >= CW'(ONE_V));
         coin_half <= (upcoming == CW'(HALF_V));
      end
   end

endmodule

// File: rtl/vending_machine_param.sv
// rtl/vending_machine_param.sv - credit-counting vending controller with refund, stock and sales count
module vending_machine_param
   import vm_pkg::*;
#(
   parameter int PRICE      = 4,
   parameter int CW         = 4,
   parameter int STOCK_INIT = 8,
   parameter int SW         = 4,
   parameter int SOLD_W     = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              pi_money_half,
   input  logic              pi_money_one,
   input  logic              pi_cancel,
   input  logic              pi_restock,
   output logic              po_cola,
   output logic              po_money_half,
   output logic              po_money_one,
   output logic              po_reject,
   output logic              po_busy,
   output logic              po_empty,
   output logic [CW-1:0]     po_credit,
   output logic [SOLD_W-1:0] po_sold
);

   vm_state_t         state, state_n;
   logic [CW-1:0]     credit, credit_n, coin_v, sum;
   logic [SW-1:0]     stock, stock_n;
   logic [SOLD_W-1:0] sold, sold_n;
   logic              coin_ok, cola_n, reject_n;
   logic              disp_load, disp_done;
   logic [CW-1:0]     disp_amount, disp_next;

   always_comb begin
      coin_v = '0;
      case ({pi_money_one, pi_money_half})
         COIN_HALF:            coin_v = CW'(HALF_V);
         COIN_ONE:             coin_v = CW'(ONE_V);
         COIN_NONE, COIN_BOTH: coin_v = '0;
      endcase
   end

   assign coin_ok = ((state == ST_IDLE) || (state == ST_ACCUM)) && (coin_v != '0) && (stock != '0);
   assign sum     = coin_ok ? credit + coin_v : credit;

   always_comb begin
      state_n     = state;
      credit_n    = credit;
      stock_n     = stock;
      sold_n      = sold;
      cola_n      = 1'b0;
      disp_load   = 1'b0;
      disp_amount = credit;
      reject_n    = (pi_money_half | pi_money_one) & ~coin_ok;
      case (state)
         ST_IDLE, ST_ACCUM: begin
            if (sum >= CW'(PRICE)) begin
               credit_n = sum - CW'(PRICE);
               stock_n  = stock - SW'(1);
               sold_n   = sold + SOLD_W'(1);
               cola_n   = 1'b1;
               state_n  = ST_VEND;
            end else if (pi_cancel && (sum != '0)) begin
               // cancel refunds the sum including a coin arriving on the same edge
               credit_n    = sum;
               disp_load   = 1'b1;
               disp_amount = sum;
               state_n     = ST_CHANGE;
            end else begin
               credit_n = sum;
               state_n  = (sum == '0) ? ST_IDLE : ST_ACCUM;
            end
         end
         ST_VEND: begin
            if (credit != '0) begin
               disp_load   = 1'b1;
               disp_amount = credit;
               state_n     = ST_CHANGE;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_CHANGE: begin
            credit_n = disp_next;
            if (disp_done)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
      if (pi_restock)
         stock_n = SW'(STOCK_INIT);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= ST_IDLE;
         credit    <= '0;
         stock     <= SW'(STOCK_INIT);
         sold      <= '0;
         po_cola   <= 1'b0;
         po_reject <= 1'b0;
         po_busy   <= 1'b0;
         po_empty  <= 1'b0;
      end else begin
         state     <= state_n;
         credit    <= credit_n;
         stock     <= stock_n;
         sold      <= sold_n;
         po_cola   <= cola_n;
         po_reject <= reject_n;
         po_busy   <= (state_n == ST_VEND) || (state_n == ST_CHANGE);
         po_empty  <= (stock_n == '0);
      end
   end

   assign po_credit = credit;
   assign po_sold   = sold;

   vm_change_dispenser #(.CW(CW)) u_change (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .load        (disp_load),
      .amount      (disp_amount),
      .coin_one    (po_money_one),
      .coin_half   (po_money_half),
      .next_amount (disp_next),
      .done        (disp_done)
   );

endmodule
